// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a wrapping register index range and streams (addr, data) beats
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] end_reg;
    logic [ADDR_W-1:0] cur_next;

    // Index increment wraps naturally at NUM_REGS because ADDR_W = log2(NUM_REGS).
    assign cur_next = cur + 1'b1;

    // Busy is simply "not idle"; it drops in the same cycle done pulses.
    assign busy = (state != IDLE);

    // Dump sequencer: latch range, read one register, hold the beat until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            end_reg   <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur     <= first_reg;
                        end_reg <= last_reg;
                        rd_addr <= first_reg;
                        state   <= READ;
                    end
                end
                READ: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        // rd_data is sampled on this edge, so a same-edge write is not seen.
                        out_data  <= rd_data;
                        out_addr  <= cur;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        // Abort wins over a coincident handshake: no done, straight to idle.
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cur == end_reg) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cur     <= cur_next;
                            rd_addr <= cur_next;
                            state   <= READ;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - scoreboard bench for regfile_dump_reader with a behavioural register file
module tb_regfile_dump_reader;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_reg;
    logic [AW-1:0] last_reg;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .first_reg(first_reg), .last_reg(last_reg),
        .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
    );

    // Behavioural register file: one write port committing on the edge, combinational read.
    logic [DW-1:0] regs [NR];
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    always @(posedge clk) if (we) regs[waddr] <= wdata;
    assign rd_data = regs[rd_addr];

    // Sink readiness: either commanded by the stimulus or randomly toggled.
    logic ready_cmd, rand_ready, rnd_bit;
    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end
    assign out_ready = rand_ready ? rnd_bit : ready_cmd;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;
    beat_t exp_q[$];
    int    hs_cyc[$];
    int    total = 0;
    int    bad = 0;
    int    exp_done = 0;
    int    done_seen = 0;
    int    cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    logic          stalled = 1'b0;
    logic [AW-1:0] held_a;
    logic [DW-1:0] held_d;
    beat_t         e;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && out_valid) begin
                check("stall_addr_stable", 64'(out_addr), 64'(held_a));
                check("stall_data_stable", 64'(out_data), 64'(held_d));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_addr), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr", 64'(out_addr), 64'(e.a));
                    check("beat_data", 64'(out_data), 64'(e.d));
                    hs_cyc.push_back(cyc);
                end
            end
            stalled = out_valid && !out_ready;
            held_a  = out_addr;
            held_d  = out_data;
            if (done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        we = 1'b1; waddr = AW'(a); wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Reference model: beat k of a dump is index (first + k) mod NR with that register's value.
    task automatic start_dump(input int f, input int l);
        int n;
        n = (((l - f) % NR) + NR) % NR + 1;
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.a = AW'((f + k) % NR);
            b.d = regs[(f + k) % NR];
            exp_q.push_back(b);
        end
        exp_done++;
        start = 1'b1; first_reg = AW'(f); last_reg = AW'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            if (done) break;
            tick();
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_gap;
        rst = 1'b1; start = 1'b0; abort = 1'b0; first_reg = '0; last_reg = '0;
        we = 1'b0; waddr = '0; wdata = '0; ready_cmd = 1'b1; rand_ready = 1'b0;
        tick(); tick();
        check("rst_rd_addr", 64'(rd_addr), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_addr", 64'(out_addr), 0);
        check("rst_out_data", 64'(out_data), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        rst = 1'b0;

        // Single-register dump timing.
        for (int i = 0; i < NR; i++) wr(i, 32'h0);
        wr(1, 32'd15);
        start_dump(1, 1);
        check("t1_busy_c1", 64'(busy), 1);
        check("t1_rd_addr_c1", 64'(rd_addr), 1);
        check("t1_valid_c1", 64'(out_valid), 0);
        tick();
        check("t1_valid_c2", 64'(out_valid), 1);
        check("t1_addr_c2", 64'(out_addr), 1);
        check("t1_data_c2", 64'(out_data), 15);
        tick();
        check("t1_done_c3", 64'(done), 1);
        check("t1_busy_c3", 64'(busy), 0);
        tick();
        check("t1_done_c4", 64'(done), 0);

        // Full dump with ready held high: 32 beats spaced 2 cycles apart.
        for (int i = 0; i < NR; i++) wr(i, DW'(i * 3));
        hs_cyc.delete();
        start_dump(0, 31);
        wait_done("full_done", 200);
        check("full_beats", 64'(hs_cyc.size()), 32);
        bad_gap = 0;
        for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 2) bad_gap++;
        check("full_spacing", 64'(bad_gap), 0);
        if (hs_cyc.size() == 32) check("full_span", 64'(hs_cyc[31] - hs_cyc[0]), 62);
        tick();
        check("full_done_single", 64'(done), 0);

        // Backpressure on beat 5.
        ready_cmd = 1'b0;
        start_dump(5, 6);
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("bp_valid_held", 64'(out_valid), 1);
        check("bp_addr_held", 64'(out_addr), 5);
        ready_cmd = 1'b1;
        wait_done("bp_done", 50);

        // Wrapping range.
        start_dump(30, 1);
        wait_done("wrap_done", 50);

        // Start while busy is ignored; abort coincident with handshake on beat 3.
        start_dump(0, 31);
        for (int k = 0; k < 4; k++) tick();
        start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
        tick();
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid && out_addr == 5'd3) break;
            tick();
        end
        check("abort_reached_beat3", 64'(out_valid && out_addr == 5'd3), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 64'(out_valid), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_no_done", 64'(done), 0);
        check("abort_left", 64'(exp_q.size()), 28);
        exp_q.delete();
        exp_done--;
        for (int k = 0; k < 4; k++) tick();

        // Reset mid-dump.
        start_dump(0, 31);
        for (int k = 0; k < 9; k++) tick();
        ready_cmd = 1'b0; rst = 1'b1;
        tick();
        check("mrst_rd_addr", 64'(rd_addr), 0);
        check("mrst_valid", 64'(out_valid), 0);
        check("mrst_addr", 64'(out_addr), 0);
        check("mrst_data", 64'(out_data), 0);
        check("mrst_busy", 64'(busy), 0);
        check("mrst_done", 64'(done), 0);
        rst = 1'b0; ready_cmd = 1'b1;
        exp_q.delete();
        exp_done--;
        tick();

        // Write to x2 committing on the edge that ends its READ: old value is reported.
        wr(2, 32'd6);
        start_dump(0, 3);
        for (int k = 0; k < 50; k++) begin
            if (busy && !out_valid && rd_addr == 5'd2) break;
            tick();
        end
        we = 1'b1; waddr = 5'd2; wdata = 32'd7;
        tick();
        we = 1'b0;
        wait_done("coh_done", 50);
        start_dump(2, 2);
        wait_done("coh_redump_done", 50);

        // Randomized ranges, contents and readiness.
        rand_ready = 1'b1;
        for (int it = 0; it < 25; it++) begin
            for (int w = 0; w < 3; w++) wr($urandom_range(0, NR - 1), $urandom);
            start_dump($urandom_range(0, NR - 1), $urandom_range(0, NR - 1));
            wait_done("rand_done", 800);
        end
        rand_ready = 1'b0;
        tick(); tick();

        check("queue_empty", 64'(exp_q.size()), 0);
        check("done_count", 64'(done_seen), 64'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
